// File: rtl/strobe_gen_if.sv
// strobe_gen_if: run-time configuration write port for strobe_gen.
//   cfg_we_i   : one-cycle write strobe
//   cfg_sel_i  : channel index being written (values >= CHANNELS are ignored)
//   cfg_mode_i : 0 = fractional phase accumulator, 1 = integer divide
//   cfg_inc_i  : increment (fractional) or divisor-minus-one (divide)
// master = configuring agent, slave = strobe_gen.
interface strobe_gen_if #(
  parameter int CHANNELS  = 4,
  parameter int ACC_WIDTH = 16,
  parameter int SEL_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                 cfg_we_i;
  logic [SEL_WIDTH-1:0] cfg_sel_i;
  logic                 cfg_mode_i;
  logic [ACC_WIDTH-1:0] cfg_inc_i;

  modport master (output cfg_we_i, cfg_sel_i, cfg_mode_i, cfg_inc_i);
  modport slave  (input  cfg_we_i, cfg_sel_i, cfg_mode_i, cfg_inc_i);
endinterface

// File: rtl/strobe_gen.sv
// strobe_gen: multi-channel clock-enable generator. Each channel emits
// single-cycle strobes either by exact integer division of clock_i or at a
// fractional rate from a phase accumulator.
//   clock_i   : system clock (only clock)
//   reset_ni  : asynchronous active-low reset
//   cfg       : configuration write port (strobe_gen_if.slave)
//   enable_i  : per-channel run enable
//   sync_i    : one-cycle phase-align (restarts every channel)
//   strobe_o  : per-channel registered one-cycle strobes

// One channel. Restart has priority over run; i_load selects whether the
// restart takes the incoming config or the channel's stored config.
module strobe_gen_ch #(
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_ni,
  input  logic                 i_restart,
  input  logic                 i_load,
  input  logic                 i_mode,
  input  logic [ACC_WIDTH-1:0] i_inc,
  input  logic                 i_en,
  output logic                 o_strobe
);
  logic                 r_mode;
  logic [ACC_WIDTH-1:0] r_inc;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_strobe;

  logic                 w_mode;
  logic [ACC_WIDTH-1:0] w_inc;
  logic [ACC_WIDTH:0]   w_sum;

  assign w_mode = i_load ? i_mode : r_mode;
  assign w_inc  = i_load ? i_inc  : r_inc;
  // Carry out of the accumulator is the fractional strobe.
  assign w_sum  = {1'b0, r_acc} + {1'b0, r_inc};

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_mode   <= 1'b0;
      r_inc    <= '0;
      r_acc    <= '0;
      r_strobe <= 1'b0;
    end else if (i_restart) begin
      r_mode   <= w_mode;
      r_inc    <= w_inc;
      // Divide mode counts down from inc so the first strobe lands inc+1
      // enabled edges later; fractional starts from zero phase.
      r_acc    <= w_mode ? w_inc : '0;
      r_strobe <= 1'b0;
    end else if (i_en) begin
      if (!r_mode) begin
        {r_strobe, r_acc} <= w_sum;
      end else if (r_acc == '0) begin
        r_acc    <= r_inc;
        r_strobe <= 1'b1;
      end else begin
        r_acc    <= r_acc - ACC_WIDTH'(1);
        r_strobe <= 1'b0;
      end
    end else begin
      // Disabled: phase holds so re-enabling resumes where it left off.
      r_strobe <= 1'b0;
    end
  end

  assign o_strobe = r_strobe;
endmodule

module strobe_gen #(
  parameter int CHANNELS  = 4,
  parameter int ACC_WIDTH = 16,
  parameter int SEL_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  strobe_gen_if.slave         cfg,
  input  logic [CHANNELS-1:0] enable_i,
  input  logic                sync_i,
  output logic [CHANNELS-1:0] strobe_o
);
  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_restart;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    // Out-of-range selects match no channel, so such writes are dropped.
    assign w_hit[c]     = cfg.cfg_we_i && (cfg.cfg_sel_i == SEL_WIDTH'(c));
    assign w_restart[c] = w_hit[c] | sync_i;

    strobe_gen_ch #(.ACC_WIDTH(ACC_WIDTH)) u_ch (
      .clock_i   (clock_i),
      .reset_ni  (reset_ni),
      .i_restart (w_restart[c]),
      .i_load    (w_hit[c]),
      .i_mode    (cfg.cfg_mode_i),
      .i_inc     (cfg.cfg_inc_i),
      .i_en      (enable_i[c]),
      .o_strobe  (strobe_o[c])
    );
  end
endmodule

// File: tb/tb_strobe_gen.sv
// tb_strobe_gen: self-checking bench for strobe_gen. The reference model
// counts enabled edges since each channel's last restart and derives strobes
// arithmetically: divide mode strobes when the count is a multiple of inc+1,
// fractional mode strobes when floor(n*inc/2^W) steps up.
// Five channels give a 3-bit select so out-of-range indices can be driven.
module tb_strobe_gen;
  localparam int NCH = 5;
  localparam int W   = 16;
  localparam int SW  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NCH-1:0] en;
  logic           sync;
  logic [NCH-1:0] strobe_o;

  int errors = 0;
  int checks = 0;

  // reference model state
  int             m_mode[NCH];
  longint         m_inc[NCH];
  longint         m_n[NCH];
  logic [NCH-1:0] m_exp;

  strobe_gen_if #(.CHANNELS(NCH), .ACC_WIDTH(W)) cfg_if ();

  strobe_gen #(.CHANNELS(NCH), .ACC_WIDTH(W)) dut (
    .clock_i  (clk),
    .reset_ni (rst_n),
    .cfg      (cfg_if),
    .enable_i (en),
    .sync_i   (sync),
    .strobe_o (strobe_o)
  );

  always #5 clk = ~clk;

  // Advance the model with the inputs present at the coming edge, then take
  // the edge and settle 1 time unit past it.
  task automatic step();
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n) begin
        m_mode[c] = 0; m_inc[c] = 0; m_n[c] = 0; m_exp[c] = 1'b0;
      end else if (sync || (cfg_if.cfg_we_i && cfg_if.cfg_sel_i == c)) begin
        if (cfg_if.cfg_we_i && cfg_if.cfg_sel_i == c) begin
          m_mode[c] = int'(cfg_if.cfg_mode_i);
          m_inc[c]  = longint'(cfg_if.cfg_inc_i);
        end
        m_n[c] = 0; m_exp[c] = 1'b0;
      end else if (en[c]) begin
        m_n[c]++;
        if (m_mode[c] != 0)
          m_exp[c] = (m_n[c] % (m_inc[c] + 1)) == 0;
        else
          m_exp[c] = ((m_n[c] * m_inc[c]) >> W) != (((m_n[c] - 1) * m_inc[c]) >> W);
      end else begin
        m_exp[c] = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int sel, input bit mode, input int inc);
    cfg_if.cfg_we_i   = 1'b1;
    cfg_if.cfg_sel_i  = SW'(sel);
    cfg_if.cfg_mode_i = mode;
    cfg_if.cfg_inc_i  = W'(inc);
    step();
    cfg_if.cfg_we_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = '1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (strobe_o !== '0) begin
        errors++; $display("FAIL reset_hold got=%b exp=0", strobe_o);
      end
    end
    #3 rst_n = 1'b1;  // release away from the clock edge
    for (int i = 0; i < 1000; i++) begin
      step();
      checks++;
      if (strobe_o !== '0) begin
        errors++; $display("FAIL reset_silent cyc=%0d got=%b exp=0", i, strobe_o);
      end
    end
  endtask

  task automatic test_frac();
    int first, cnt;
    first = -1; cnt = 0;
    cfg_write(0, 1'b0, 1024);
    for (int i = 1; i <= 640; i++) begin
      step();
      checks++;
      if (strobe_o !== m_exp) begin
        errors++; $display("FAIL frac_model cyc=%0d got=%b exp=%b", i, strobe_o, m_exp);
      end
      if (strobe_o[0] === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (first != 64) begin
      errors++; $display("FAIL frac_first got=%0d exp=64", first);
    end
    checks++;
    if (cnt != 10) begin
      errors++; $display("FAIL frac_count got=%0d exp=10", cnt);
    end
  endtask

  task automatic test_div();
    int first, second;
    first = -1; second = -1;
    cfg_write(1, 1'b1, 63);
    for (int i = 1; i <= 130; i++) begin
      step();
      checks++;
      if (strobe_o !== m_exp) begin
        errors++; $display("FAIL div_model cyc=%0d got=%b exp=%b", i, strobe_o, m_exp);
      end
      if (strobe_o[1] === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    checks++;
    if (first != 64 || second != 128) begin
      errors++; $display("FAIL div_period got=%0d,%0d exp=64,128", first, second);
    end
    cfg_write(1, 1'b1, 0);
    checks++;
    if (strobe_o[1] !== 1'b0) begin
      errors++; $display("FAIL div0_write_edge got=%b exp=0", strobe_o[1]);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (strobe_o[1] !== 1'b1) begin
        errors++; $display("FAIL div0_every cyc=%0d got=%b exp=1", i, strobe_o[1]);
      end
    end
  endtask

  task automatic test_frac_gap();
    logic [7:0] pat_a, pat_b;
    int cnt;
    cfg_write(2, 1'b0, 16'h6000);
    for (int w = 0; w < 4; w++) begin
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        checks++;
        if (strobe_o !== m_exp) begin
          errors++; $display("FAIL gap_model got=%b exp=%b", strobe_o, m_exp);
        end
        if (w == 0) pat_a[i] = strobe_o[2];
        if (strobe_o[2] === 1'b1) cnt++;
      end
      checks++;
      if (cnt != 3) begin
        errors++; $display("FAIL frac38_window w=%0d got=%0d exp=3", w, cnt);
      end
    end
    checks++;
    if (pat_a !== 8'b1010_0100) begin
      errors++; $display("FAIL frac38_pattern got=%b exp=10100100", pat_a);
    end
    en[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (strobe_o[2] !== 1'b0) begin
        errors++; $display("FAIL gap_silent cyc=%0d got=%b exp=0", i, strobe_o[2]);
      end
    end
    en[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      pat_b[i] = strobe_o[2];
      checks++;
      if (strobe_o !== m_exp) begin
        errors++; $display("FAIL gap_resume_model got=%b exp=%b", strobe_o, m_exp);
      end
    end
    checks++;
    if (pat_b !== pat_a) begin
      errors++; $display("FAIL gap_phase got=%b exp=%b", pat_b, pat_a);
    end
  endtask

  task automatic test_sync();
    int f0, f1;
    en = '1;
    cfg_write(0, 1'b1, 9);
    cfg_write(1, 1'b1, 4);
    for (int i = 0; i < 3; i++) step();
    sync = 1'b1; step(); sync = 1'b0;
    checks++;
    if (strobe_o !== '0) begin
      errors++; $display("FAIL sync_edge got=%b exp=0", strobe_o);
    end
    f0 = -1; f1 = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (strobe_o !== m_exp) begin
        errors++; $display("FAIL sync_model cyc=%0d got=%b exp=%b", i, strobe_o, m_exp);
      end
      if (strobe_o[0] === 1'b1 && f0 < 0) f0 = i;
      if (strobe_o[1] === 1'b1 && f1 < 0) f1 = i;
      if (i == 10 || i == 20) begin
        checks++;
        if (strobe_o[1:0] !== 2'b11) begin
          errors++; $display("FAIL sync_coincide cyc=%0d got=%b exp=11", i, strobe_o[1:0]);
        end
      end
    end
    checks++;
    if (f0 != 10 || f1 != 5) begin
      errors++; $display("FAIL sync_first got=%0d,%0d exp=10,5", f0, f1);
    end
    // sync coincident with a write to ch1
    sync = 1'b1;
    cfg_write(1, 1'b1, 2);
    sync = 1'b0;
    checks++;
    if (strobe_o[1:0] !== 2'b00) begin
      errors++; $display("FAIL syncwr_edge got=%b exp=00", strobe_o[1:0]);
    end
    f0 = -1; f1 = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (strobe_o !== m_exp) begin
        errors++; $display("FAIL syncwr_model cyc=%0d got=%b exp=%b", i, strobe_o, m_exp);
      end
      if (strobe_o[0] === 1'b1 && f0 < 0) f0 = i;
      if (strobe_o[1] === 1'b1 && f1 < 0) f1 = i;
    end
    checks++;
    if (f0 != 10 || f1 != 3) begin
      errors++; $display("FAIL syncwr_first got=%0d,%0d exp=10,3", f0, f1);
    end
  endtask

  task automatic test_bad_sel();
    for (int s = 5; s <= 7; s++) begin
      cfg_write(s, 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)));
      for (int i = 0; i < 30; i++) begin
        step();
        checks++;
        if (strobe_o !== m_exp) begin
          errors++; $display("FAIL bad_sel sel=%0d cyc=%0d got=%b exp=%b", s, i, strobe_o, m_exp);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        cfg_if.cfg_we_i   = 1'b1;
        cfg_if.cfg_sel_i  = SW'($urandom_range(0, 7));
        cfg_if.cfg_mode_i = 1'($urandom_range(0, 1));
        cfg_if.cfg_inc_i  = cfg_if.cfg_mode_i ? W'($urandom_range(0, 31))
                                              : W'($urandom_range(0, 65535));
      end else begin
        cfg_if.cfg_we_i = 1'b0;
      end
      for (int c = 0; c < NCH; c++) en[c] = ($urandom_range(0, 7) != 0);
      sync = ($urandom_range(0, 63) == 0);
      step();
      checks++;
      if (strobe_o !== m_exp) begin
        errors++; $display("FAIL random cyc=%0d got=%b exp=%b", i, strobe_o, m_exp);
      end
    end
    cfg_if.cfg_we_i = 1'b0;
    sync = 1'b0;
    en = '1;
  endtask

  task automatic test_async_reset();
    cfg_write(1, 1'b1, 0);
    step();
    checks++;
    if (strobe_o[1] !== 1'b1) begin
      errors++; $display("FAIL areset_pre got=%b exp=1", strobe_o[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (strobe_o !== '0) begin
      errors++; $display("FAIL areset_async got=%b exp=0", strobe_o);
    end
    for (int i = 0; i < 3; i++) step();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (strobe_o !== '0) begin
        errors++; $display("FAIL areset_cfg_lost cyc=%0d got=%b exp=0", i, strobe_o);
      end
    end
  endtask

  initial begin
    en = '0;
    sync = 1'b0;
    cfg_if.cfg_we_i = 1'b0;
    cfg_if.cfg_sel_i = '0;
    cfg_if.cfg_mode_i = 1'b0;
    cfg_if.cfg_inc_i = '0;
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_inc[c] = 0; m_n[c] = 0;
    end
    m_exp = '0;
    #2;
    test_reset();
    test_frac();
    test_div();
    test_frac_gap();
    test_sync();
    test_bad_sel();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
